gate_tt_sequencer: RTL and testbench

- Stimulus-and-check block for 2-input combinational gates such as nor_gate, and the initiating end of that interface.
- On a start pulse it drives the four input combinations {a,b} = 00, 01, 10, 11 onto the device under test (DUT) and waits a programmable settle time after each one.
- It then samples the gate output and compares it against a parameterised expected truth table.
- It reports per-vector mismatches, a pass flag and a one-cycle done pulse.
- It is used for on-board self-test of the lab gate modules.

---
 rtl/gate_tt_sequencer.sv | 122 ++++++++++++
 tb/tb_gate_tt_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: applies the four {a,b} input vectors to a 2-input gate,
// waits a programmable settle time, samples f_i and compares it against an
// expected truth table. Reports a per-vector fail mask, a pass flag and a
// one-cycle done pulse.
// Optional feature macro: GATE_CHK_STOP_ON_FAIL_EN (the first mismatch ends the run).
module gate_tt_sequencer #(
  parameter logic [3:0] EXPECTED_TT   = 4'b0001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  input  logic       f_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       mismatch;

  // f_i is only meaningful in SAMPLE; elsewhere this is don't-care
  assign mismatch = (f_i != EXPECTED_TT[vec_idx]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = (SETTLE_LD == 4'd0) ? S_SAMPLE : S_SETTLE;
      // Leaving on count==1 makes SETTLE last exactly SETTLE_CYCLES cycles
      S_SETTLE: if (settle_cnt <= 4'd1) state_nxt = S_SAMPLE;
      S_SAMPLE: begin
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (mismatch || vec_idx == 2'd3) state_nxt = S_DONE;
        else                             state_nxt = S_DRIVE;
`else
        if (vec_idx == 2'd3) state_nxt = S_DONE;
        else                 state_nxt = S_DRIVE;
`endif
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_DRIVE, S_SETTLE, S_SAMPLE: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default: ;
    endcase
  end

  // Vector drive, settle counter, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      vec_idx    <= 2'd0;
      fail_mask  <= 4'd0;
      pass       <= 1'b0;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx   <= 2'd0;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
          end
        end
        S_DRIVE: begin
          {a_o, b_o} <= vec_idx;
          settle_cnt <= SETTLE_LD;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        S_SAMPLE: begin
          fail_mask[vec_idx] <= mismatch;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
          // On a mismatch vec_idx is left pointing at the failing vector
          if (!mismatch && vec_idx != 2'd3) vec_idx <= vec_idx + 2'd1;
`else
          if (vec_idx != 2'd3) vec_idx <= vec_idx + 2'd1;
`endif
        end
        S_DONE: begin
          // fail_mask already holds the vector-3 result here
          pass <= (fail_mask == 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: dut_a uses default parameters,
// dut_b uses SETTLE_CYCLES=0. A behavioural gate model closes the loop.
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       a_a, b_a, f_a, busy_a, done_a, pass_a;
  logic       a_b, b_b, f_b, busy_b, done_b, pass_b;
  logic [3:0] fm_a, fm_b;
  logic [1:0] vi_a, vi_b;
  int         mode_a, mode_b;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // 0: NOR, 1: OR, 2: stuck at 1, 3: NOR wrong only for {a,b}=01
  function automatic logic gate_f(input int mode, input logic a, input logic b);
    case (mode)
      0:       return ~(a | b);
      1:       return a | b;
      2:       return 1'b1;
      3:       return ~(a | b) ^ (~a & b);
      default: return 1'b0;
    endcase
  endfunction

  assign f_a = gate_f(mode_a, a_a, b_a);
  assign f_b = gate_f(mode_b, a_b, b_b);

  gate_tt_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .a_o(a_a), .b_o(b_a), .f_i(f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(fm_a), .vec_idx(vi_a)
  );

  gate_tt_sequencer #(.EXPECTED_TT(4'b0001), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .a_o(a_b), .b_o(b_b), .f_i(f_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(fm_b), .vec_idx(vi_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One run on dut_a (sel=0) or dut_b (sel=1); start re-pulsed at cycles re1/re2 (0=none).
  // Cycle k is the k-th cycle after the edge that samples start.
  task automatic run(input int sel, input int re1, input int re2,
                     output int done_cyc, output int done_cnt, output int fm,
                     output int vi, output int ps, output int seq, output int nvec,
                     output int busy1);
    int last;
    int ab;
    done_cyc = 0; done_cnt = 0; fm = -1; vi = -1; ps = -1;
    seq = 0; nvec = 0; busy1 = 0; last = -1;
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sel == 0) start_a = (k == re1 || k == re2);
      else          start_b = (k == re1 || k == re2);
      if (k == 1) busy1 = (sel == 0) ? int'(busy_a) : int'(busy_b);
      ab = (sel == 0) ? int'({a_a, b_a}) : int'({a_b, b_b});
      // from cycle 2 on the DUT inputs carry this run's vectors
      if (k >= 2 && ((sel == 0) ? busy_a : busy_b)) begin
        if (nvec == 0 || ab != last) begin
          seq = seq * 4 + ab;
          nvec++;
          last = ab;
        end
      end
      if ((sel == 0) ? done_a : done_b) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = k;
          fm = (sel == 0) ? int'(fm_a) : int'(fm_b);
          vi = (sel == 0) ? int'(vi_a) : int'(vi_b);
        end
      end
      if (done_cyc != 0 && k == done_cyc + 1)
        ps = (sel == 0) ? int'(pass_a) : int'(pass_b);
    end
  endtask

  int dc, dn, fm, vi, ps, seq, nv, b1, dsum;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode_a = 0; mode_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", int'({a_a, b_a, busy_a, done_a, pass_a, fm_a, vi_a}), 0);
    chk("reset_outs_b", int'({a_b, b_b, busy_b, done_b, pass_b, fm_b, vi_b}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal NOR, default settle
    mode_a = 0;
    run(0, 0, 0, dc, dn, fm, vi, ps, seq, nv, b1);
    chk("nor_done_cyc", dc, 17);
    chk("nor_done_cnt", dn, 1);
    chk("nor_busy_c1", b1, 1);
    chk("nor_fail_mask", fm, 0);
    chk("nor_vec_idx", vi, 3);
    chk("nor_pass", ps, 1);
    chk("nor_vec_seq", seq, 27);
    chk("nor_vec_cnt", nv, 4);

    // DUT wired as OR
    mode_a = 1;
    run(0, 0, 0, dc, dn, fm, vi, ps, seq, nv, b1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("or_done_cyc", dc, 5);
    chk("or_fail_mask", fm, 1);
    chk("or_vec_idx", vi, 0);
`else
    chk("or_done_cyc", dc, 17);
    chk("or_fail_mask", fm, 15);
`endif
    chk("or_pass", ps, 0);

    // f stuck at 1, zero settle
    mode_b = 2;
    run(1, 0, 0, dc, dn, fm, vi, ps, seq, nv, b1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("stuck_done_cyc", dc, 5);
    chk("stuck_fail_mask", fm, 2);
`else
    chk("stuck_done_cyc", dc, 9);
    chk("stuck_fail_mask", fm, 14);
`endif
    chk("stuck_pass", ps, 0);

    // Reset asserted in cycle 6, released in cycle 8, restart afterwards
    mode_a = 0;
    dsum = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k == 6) rst_n = 1'b0;
      if (k == 8) rst_n = 1'b1;
      #1;
      if (k == 6 || k == 7)
        chk("midrun_reset_outs", int'({a_a, b_a, busy_a, done_a, pass_a, fm_a, vi_a}), 0);
      if (done_a) dsum++;
    end
    chk("midrun_no_done", dsum, 0);
    run(0, 0, 0, dc, dn, fm, vi, ps, seq, nv, b1);
    chk("rerun_done_cyc", dc, 17);
    chk("rerun_pass", ps, 1);

    // start re-pulsed mid-run must be ignored
    run(0, 3, 10, dc, dn, fm, vi, ps, seq, nv, b1);
    chk("repulse_done_cnt", dn, 1);
    chk("repulse_done_cyc", dc, 17);
    chk("repulse_pass", ps, 1);

    // DUT wrong only for {a,b}=01
    mode_a = 3;
    run(0, 0, 0, dc, dn, fm, vi, ps, seq, nv, b1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    chk("w01_done_cyc", dc, 9);
    chk("w01_vec_idx", vi, 1);
    chk("w01_vec_seq", seq, 1);
    chk("w01_vec_cnt", nv, 2);
`else
    chk("w01_done_cyc", dc, 17);
    chk("w01_vec_idx", vi, 3);
    chk("w01_vec_seq", seq, 27);
    chk("w01_vec_cnt", nv, 4);
`endif
    chk("w01_fail_mask", fm, 2);
    chk("w01_pass", ps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
